// File: rtl/vdp_status_ctl.sv
// VDP status register (F, 5S, C, fifth-sprite number) and interrupt line; flags set on events, snapshot+clear on CPU read.
// Flags and status update one clk after the event/read; irq is combinational in ie; no backpressure, every tick is consumed.
module vdp_status_ctl #(
  parameter bit VBLANK_RISING = 1'b1,
  parameter int MISS_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic              ie,
  input  logic              coinc_tick,
  input  logic              fifth_tick,
  input  logic [4:0]        fifth_num,
  input  logic              rd_tick,
  output logic [7:0]        status,
  output logic              irq,
  output logic [MISS_W-1:0] frame_miss
);

  logic              vblank_q;
  logic              frame_tick;
  logic              f_q, f_d;
  logic              c_q, c_d;
  logic              s5_q, s5_d;
  logic [4:0]        num_q, num_d;
  logic [7:0]        status_q, status_d;
  logic [MISS_W-1:0] miss_q, miss_d;

  assign frame_tick = VBLANK_RISING ? (vblank & ~vblank_q) : (~vblank & vblank_q);

  always_comb begin
    f_d      = frame_tick | (f_q & ~rd_tick);
    c_d      = coinc_tick | (c_q & ~rd_tick);
    s5_d     = s5_q;
    num_d    = num_q;
    status_d = status_q;
    miss_d   = miss_q;

    // A read frees the slot, so a same-cycle fifth_tick captures a fresh number.
    if (fifth_tick && (!s5_q || rd_tick)) begin
      s5_d  = 1'b1;
      num_d = fifth_num;
    end else if (rd_tick) begin
      s5_d = 1'b0;
    end

    // Snapshot takes pre-update values; same-cycle events show up on the next read.
    if (rd_tick) begin
      status_d = {f_q, s5_q, c_q, num_q};
    end

    if (rd_tick) begin
      miss_d = '0;
    end else if (frame_tick && f_q && (miss_q != {MISS_W{1'b1}})) begin
      miss_d = miss_q + 1'b1;
    end
  end

  // vblank_q resets to the active level so a vblank already active at release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_q <= VBLANK_RISING;
      f_q      <= 1'b0;
      c_q      <= 1'b0;
      s5_q     <= 1'b0;
      num_q    <= '0;
      status_q <= '0;
      miss_q   <= '0;
    end else begin
      vblank_q <= vblank;
      f_q      <= f_d;
      c_q      <= c_d;
      s5_q     <= s5_d;
      num_q    <= num_d;
      status_q <= status_d;
      miss_q   <= miss_d;
    end
  end

  assign status     = status_q;
  assign irq        = f_q & ie;
  assign frame_miss = miss_q;

endmodule

// File: tb/tb_vdp_status_ctl.sv
// Directed table-driven bench for vdp_status_ctl plus hand sequences for saturation and mid-run reset.
module tb_vdp_status_ctl;

  logic       clk = 1'b0;
  logic       reset;
  logic       vblank;
  logic       ie;
  logic       coinc_tick;
  logic       fifth_tick;
  logic [4:0] fifth_num;
  logic       rd_tick;
  logic [7:0] status;
  logic       irq;
  logic [3:0] frame_miss;

  int checks = 0;
  int errors = 0;

  vdp_status_ctl #(.VBLANK_RISING(1'b1), .MISS_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .vblank     (vblank),
    .ie         (ie),
    .coinc_tick (coinc_tick),
    .fifth_tick (fifth_tick),
    .fifth_num  (fifth_num),
    .rd_tick    (rd_tick),
    .status     (status),
    .irq        (irq),
    .frame_miss (frame_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vb;
    logic       ie;
    logic       co;
    logic       ft;
    logic [4:0] fn;
    logic       rd;
    logic [7:0] st;
    logic       irq;
    logic [3:0] miss;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic vb, input logic ie_v, input logic co, input logic ft,
                     input logic [4:0] fn, input logic rd,
                     input logic [7:0] st, input logic irq_v, input logic [3:0] miss);
    vec_t v;
    v.vb = vb; v.ie = ie_v; v.co = co; v.ft = ft; v.fn = fn; v.rd = rd;
    v.st = st; v.irq = irq_v; v.miss = miss;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vb, input logic ie_v, input logic co, input logic ft,
                       input logic [4:0] fn, input logic rd);
    @(negedge clk);
    vblank = vb; ie = ie_v; coinc_tick = co; fifth_tick = ft; fifth_num = fn; rd_tick = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; vblank = 1'b1; ie = 1'b1;
    coinc_tick = 1'b0; fifth_tick = 1'b0; fifth_num = 5'd0; rd_tick = 1'b0;

    //    vb ie co ft fn     rd  status  irq miss
    add(1, 1, 0, 0, 5'd0,  0, 8'h00, 0, 0);  // vblank high since reset: no event
    add(0, 1, 0, 0, 5'd0,  0, 8'h00, 0, 0);
    add(1, 1, 0, 0, 5'd0,  0, 8'h00, 1, 0);  // rising edge sets F
    add(1, 1, 0, 0, 5'd0,  1, 8'h80, 0, 0);
    add(0, 1, 0, 1, 5'd7,  0, 8'h80, 0, 0);
    add(0, 1, 0, 1, 5'd3,  0, 8'h80, 0, 0);  // second fifth ignored
    add(0, 1, 0, 0, 5'd0,  1, 8'h47, 0, 0);
    add(0, 1, 0, 0, 5'd0,  1, 8'h07, 0, 0);  // 5S clear, num held
    add(1, 1, 0, 0, 5'd0,  0, 8'h07, 1, 0);
    add(0, 1, 0, 0, 5'd0,  0, 8'h07, 1, 0);
    add(1, 1, 0, 0, 5'd0,  1, 8'h87, 1, 0);  // read + frame edge: F kept, no miss
    add(0, 1, 1, 0, 5'd0,  0, 8'h87, 1, 0);
    add(0, 1, 1, 0, 5'd0,  1, 8'hA7, 0, 0);  // read + coinc: C kept
    add(0, 1, 0, 0, 5'd0,  1, 8'h27, 0, 0);
    add(0, 0, 0, 0, 5'd0,  0, 8'h27, 0, 0);
    add(1, 0, 0, 0, 5'd0,  0, 8'h27, 0, 0);  // F set but masked
    add(1, 1, 0, 0, 5'd0,  0, 8'h27, 1, 0);  // ie rises: irq immediately
    add(0, 1, 0, 1, 5'h1F, 1, 8'h87, 0, 0);  // read + fifth: fresh capture
    add(0, 1, 0, 0, 5'd0,  1, 8'h5F, 0, 0);
    add(0, 1, 0, 0, 5'd0,  0, 8'h5F, 0, 0);
    add(1, 1, 0, 0, 5'd0,  0, 8'h5F, 1, 0);
    add(0, 1, 0, 0, 5'd0,  0, 8'h5F, 1, 0);
    add(1, 1, 0, 0, 5'd0,  0, 8'h5F, 1, 1);  // frame lost
    add(0, 1, 0, 0, 5'd0,  0, 8'h5F, 1, 1);
    add(1, 1, 0, 0, 5'd0,  1, 8'h9F, 1, 0);  // read clears miss despite edge

    repeat (2) @(posedge clk);
    #1;
    chk("reset_status", status, 8'h00);
    chk("reset_irq", irq, 1'b0);
    chk("reset_miss", frame_miss, 4'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].vb, vecs[i].ie, vecs[i].co, vecs[i].ft, vecs[i].fn, vecs[i].rd);
      chk($sformatf("vec%0d_status", i), status, vecs[i].st);
      chk($sformatf("vec%0d_irq", i), irq, vecs[i].irq);
      chk($sformatf("vec%0d_miss", i), frame_miss, vecs[i].miss);
    end

    // F is still set: every further edge counts as lost, saturating at 15.
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0, 0, 5'd0, 0);
      drive(1, 1, 0, 0, 5'd0, 0);
      chk($sformatf("sat%0d_miss", i), frame_miss, (i + 1 > 15) ? 15 : i + 1);
    end
    chk("sat_irq", irq, 1'b1);
    drive(1, 1, 0, 0, 5'd0, 1);
    chk("sat_clear_miss", frame_miss, 4'd0);
    chk("sat_clear_status", status, 8'h9F);
    chk("sat_clear_irq", irq, 1'b0);

    drive(0, 1, 0, 0, 5'd0, 0);
    drive(1, 1, 1, 0, 5'd0, 0);
    chk("pre_reset_irq", irq, 1'b1);

    // Async reset mid-cycle with vblank high and a pending coinc tick.
    @(negedge clk);
    coinc_tick = 1'b1; vblank = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_reset_status", status, 8'h00);
    chk("mid_reset_irq", irq, 1'b0);
    chk("mid_reset_miss", frame_miss, 4'd0);
    @(posedge clk);
    @(negedge clk);
    coinc_tick = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 5'd0, 0);
      chk($sformatf("post_reset%0d_irq", i), irq, 1'b0);
    end
    drive(1, 1, 0, 0, 5'd0, 1);
    chk("post_reset_read", status, 8'h00);
    drive(0, 1, 0, 0, 5'd0, 0);
    drive(1, 1, 0, 0, 5'd0, 0);
    chk("post_reset_edge_irq", irq, 1'b1);
    drive(1, 1, 0, 0, 5'd0, 1);
    chk("post_reset_edge_status", status, 8'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
